video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates HDMI raster timing and drives the per-channel TMDS encoders.
- Pulls 24-bit RGB pixels from an upstream valid/ready stream and emits registered pixel data, DE, hsync and vsync.
- Raster timing never stalls; stream underflow and frame misalignment are absorbed by blanking pixels to black and resynchronising.
- Downstream: DE drives the encoders' data-valid input; hsync/vsync drive ctl_0/ctl_1 of the blue-channel encoder.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width
V_BP, 20, vertical back porch
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  generator enable
px_data_i  in  24  upstream pixel {R,G,B}
px_sof_i  in  1  upstream start-of-frame marker (first pixel)
px_valid_i  in  1  upstream valid
px_ready_o  out  1  upstream ready (combinational)
px_data_o  out  24  pixel to encoders
de_o  out  1  data enable
hsync_o  out  1  hsync, polarity applied
vsync_o  out  1  vsync, polarity applied
underflow_o  out  1  one-cycle pulse: black pixel inserted in RUN
misalign_o  out  1  one-cycle pulse: SOF mismatch detected

Behaviour:
- One clock, clk_i; reset rst_i is asynchronous, active-high.
- Reset values:
  - h_cnt = 0, v_cnt = 0, state WAIT_SOF.
  - px_data_o = 0, de_o = 0, underflow_o = 0, misalign_o = 0.
  - hsync_o = !HS_POL, vsync_o = !VS_POL.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter widths: $clog2 of each total.
- Counters:
  - h_cnt wraps at H_TOTAL-1.
  - v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1.
  - Both are held at 0 while en_i is low.
- Region decode:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Latency:
  - All outputs are registered, one cycle after the counter value they decode.
  - A beat accepted in cycle t appears on px_data_o in cycle t+1 with de_o = 1.
- en_i low:
  - State forced to WAIT_SOF; outputs at their reset values; px_ready_o = 0.
- State machine:
  - WAIT_SOF:
    - px_ready_o = !px_sof_i, so non-SOF beats are discarded.
    - A valid beat with SOF is held, not consumed; go to ALIGN.
  - ALIGN:
    - px_ready_o = 0.
    - When h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, go to RUN.
  - RUN:
    - px_ready_o = active && !(px_sof_i && !first), where first = (h_cnt = 0 && v_cnt = 0).
    - Active cycle, valid beat accepted: px_data_o = px_data_i.
    - Active cycle, px_valid_i low: px_data_o = 0 (black), de_o = 1, underflow_o pulses; stay in RUN.
    - Valid SOF beat at a non-first active position: beat not consumed; black for the rest of the frame; misalign_o pulses; go to ALIGN.
    - First-pixel beat accepted without SOF: beat consumed but output black; misalign_o pulses; go to WAIT_SOF; black for the rest of the frame.
- Outside RUN: de_o still follows the active region with px_data_o = 0, so DE timing is unbroken. underflow_o stays 0.
- Blanking cycles: px_data_o = 0.
- Simultaneous SOF and underflow in one cycle: cannot occur; SOF requires valid.
- Reset mid-frame: immediate return to reset values; no partial-line recovery.

Decomposition:
- Package video_timing_pkg:
  - rgb_px_t (24-bit packed struct {r,g,b}).
  - vtg_state_t enum {WAIT_SOF, ALIGN, RUN}.
  - localparams for the 720p60 and 1080p60 timing sets.
- One sub-module, raster_counter:
  - Contains h_cnt/v_cnt, region decode and the frame-end flag.
  - video_timing_gen instantiates it plus the stream FSM and output registers.

Test Plan:
- Test timing set: H 8/2/2/2, V 4/1/1/1 (H_TOTAL 14, V_TOTAL 7).
- Reset/idle: en_i = 0 for 50 cycles -> de_o = 0, hsync_o = vsync_o = 0 (inactive for POL = 1), px_ready_o = 0.
- Timing check: continuous valid stream, SOF on beat 0 of every 32-beat frame -> de_o high 8 cycles per line on 4 lines; hsync_o high at output cycles 11-12 of each line; vsync_o high for line 5; frame period 98 cycles.
- Pixel ordering: ramp data 0x000000..0x00001F with SOF on 0 -> px_data_o emits 0x00..0x1F in order, first value one cycle after the frame-start handshake.
- Underflow: drop px_valid_i for pixel 3 of line 1 -> px_data_o = 0 and underflow_o = 1 in that DE cycle; remaining pixels shift by one, state stays RUN.
- Early SOF: SOF beat presented at pixel 5 of line 2 -> misalign_o pulses; black for the remainder of the frame; that beat is consumed at pixel 0 of the next frame.
- Discard: 10 non-SOF beats before the first SOF -> all consumed while de_o = 0; first displayed pixel is the SOF beat.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and standard timing sets for the HDMI raster timing generator.
package video_timing_pkg;

  // One pixel as it travels from the upstream stream to the TMDS encoders.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_px_t;

  // Stream alignment state: hunt for SOF, wait for frame boundary, stream.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ALIGN    = 2'd1,
    RUN      = 2'd2
  } vtg_state_t;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock).
  localparam int P720_H_ACTIVE  = 1280;
  localparam int P720_H_FP      = 110;
  localparam int P720_H_SYNC    = 40;
  localparam int P720_H_BP      = 220;
  localparam int P720_V_ACTIVE  = 720;
  localparam int P720_V_FP      = 5;
  localparam int P720_V_SYNC    = 5;
  localparam int P720_V_BP      = 20;

  // 1920x1080 @ 60 Hz (148.5 MHz pixel clock).
  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  // Counter width able to hold 0..total-1 (at least one bit).
  function automatic int cnt_width(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Free-running h/v raster counters with region decode and frame-end flag.
// All decode outputs are combinational from the current counter values.
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic first_o,
  output logic frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;

  assign h_wrap = (h_cnt_q == H_LAST);

  // Next raster position: h wraps at end of line, v advances on h wrap.
  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Counter registers; parked at the frame origin while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (!en_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vsync_o     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign first_o     = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end_o = h_wrap && (v_cnt_q == V_LAST);

endmodule

// File: rtl/video_timing_gen.sv
// HDMI raster timing generator: aligns an upstream RGB stream to the raster
// and drives registered pixel data, DE and syncs to the TMDS encoders.
// The raster never stalls; underflow and misalignment are blanked to black.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [23:0] px_data_i,
  input  logic        px_sof_i,
  input  logic        px_valid_i,
  output logic        px_ready_o,
  output logic [23:0] px_data_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        underflow_o,
  output logic        misalign_o
);

  logic active, hs_raw, vs_raw, first, frame_end;

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .active_o    (active),
    .hsync_o     (hs_raw),
    .vsync_o     (vs_raw),
    .first_o     (first),
    .frame_end_o (frame_end)
  );

  vtg_state_t state_q, state_d;
  rgb_px_t    px_data_q, px_data_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       underflow_q, underflow_d;
  logic       misalign_q, misalign_d;

  // Upstream ready: discard non-SOF beats while hunting, hold SOF beats
  // until the frame origin, and in RUN accept only in-order beats.
  always_comb begin
    px_ready_o = 1'b0;
    if (en_i) begin
      case (state_q)
        WAIT_SOF: px_ready_o = !px_sof_i;
        ALIGN:    px_ready_o = 1'b0;
        RUN:      px_ready_o = active && !(px_sof_i && !first);
        default:  px_ready_o = 1'b0;
      endcase
    end
  end

  // Next state and next output values for the cycle being decoded now.
  always_comb begin
    state_d     = state_q;
    px_data_d   = '0;
    underflow_d = 1'b0;
    misalign_d  = 1'b0;
    de_d        = en_i && active;
    hsync_d     = (en_i && hs_raw) ? HS_POL : !HS_POL;
    vsync_d     = (en_i && vs_raw) ? VS_POL : !VS_POL;
    if (!en_i) begin
      state_d = WAIT_SOF;
    end else begin
      case (state_q)
        WAIT_SOF: if (px_valid_i && px_sof_i) state_d = ALIGN;
        ALIGN:    if (frame_end) state_d = RUN;
        RUN: begin
          if (active) begin
            if (!px_valid_i) begin
              underflow_d = 1'b1;
            end else if (first && !px_sof_i) begin
              // Frame origin reached without SOF: drop it and re-hunt.
              misalign_d = 1'b1;
              state_d    = WAIT_SOF;
            end else if (!first && px_sof_i) begin
              // Next frame arrived early: keep its SOF beat for the origin.
              misalign_d = 1'b1;
              state_d    = ALIGN;
            end else begin
              px_data_d = px_data_i;
            end
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WAIT_SOF;
      px_data_q   <= '0;
      de_q        <= 1'b0;
      hsync_q     <= !HS_POL;
      vsync_q     <= !VS_POL;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_data_q   <= px_data_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
    end
  end

  assign px_data_o   = px_data_q;
  assign de_o        = de_q;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign underflow_o = underflow_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a tiny raster (H 8/2/2/2, V 4/1/1/1).
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 14
  localparam int VT = VA + VF + VSW + VB;   // 7
  localparam int FT = HT * VT;              // 98

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, px_sof_i, px_valid_i;
  logic [23:0] px_data_i;
  logic        px_ready_o, de_o, hsync_o, vsync_o, underflow_o, misalign_o;
  logic [23:0] px_data_o;

  always #5 clk_i = ~clk_i;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
    .px_data_i(px_data_i), .px_sof_i(px_sof_i), .px_valid_i(px_valid_i),
    .px_ready_o(px_ready_o), .px_data_o(px_data_o), .de_o(de_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o),
    .underflow_o(underflow_o), .misalign_o(misalign_o)
  );

  typedef struct { logic [23:0] data; bit sof; } beat_t;
  beat_t src_q[$];

  int n_cmp = 0, n_fail = 0;

  // Reference model: raster position within the frame and sync status
  // (0 hunting for SOF, 1 holding SOF until frame origin, 2 locked).
  int pos, mode;
  logic [23:0] e_data;
  bit e_de, e_hs, e_vs, e_uf, e_ma;

  // Observations for the directed checks.
  int cyc, uf_seen, ma_seen, win_lo;
  int vs_rise[$];
  logic [23:0] col[$];
  bit vs_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; mode = 0;
    e_data = '0; e_de = 0; e_hs = 0; e_vs = 0; e_uf = 0; e_ma = 0;
  endtask

  task automatic check_outputs();
    chk("px_data", px_data_o, e_data);
    chk("de", de_o, e_de);
    chk("hsync", hsync_o, e_hs);
    chk("vsync", vsync_o, e_vs);
    chk("underflow", underflow_o, e_uf);
    chk("misalign", misalign_o, e_ma);
    if (underflow_o === 1'b1) uf_seen++;
    if (misalign_o === 1'b1) ma_seen++;
    if (vsync_o === 1'b1 && !vs_prev) vs_rise.push_back(cyc);
    vs_prev = (vsync_o === 1'b1);
    if (cyc >= win_lo && cyc < win_lo + FT && de_o === 1'b1) col.push_back(px_data_o);
  endtask

  // One clock: check outputs, drive inputs, predict, check ready, handshake.
  task automatic step(input bit en, input bit want_valid);
    int h, v;
    bit act, first, hsr, vsr, rdy, vld, sof;
    check_outputs();
    vld = want_valid && (src_q.size() > 0);
    sof = vld ? src_q[0].sof : 1'b0;
    en_i = en;
    px_valid_i = vld;
    px_sof_i = sof;
    px_data_i = vld ? src_q[0].data : 24'($urandom);
    h = pos % HT;
    v = pos / HT;
    act = (h < HA) && (v < VA);
    first = (pos == 0);
    hsr = (h >= HA + HF) && (h < HA + HF + HSW);
    vsr = (v >= VA + VF) && (v < VA + VF + VSW);
    rdy = 0;
    if (en) begin
      if (mode == 0) rdy = !sof;
      else if (mode == 2) rdy = act && !(sof && !first);
    end
    e_de = en && act; e_hs = en && hsr; e_vs = en && vsr;
    e_data = '0; e_uf = 0; e_ma = 0;
    if (!en) mode = 0;
    else if (mode == 0) begin
      if (vld && sof) mode = 1;
    end else if (mode == 1) begin
      if (pos == FT - 1) mode = 2;
    end else if (act) begin
      if (!vld) e_uf = 1;
      else if (first && !sof) begin e_ma = 1; mode = 0; end
      else if (!first && sof) begin e_ma = 1; mode = 1; end
      else e_data = px_data_i;
    end
    pos = en ? (pos + 1) % FT : 0;
    #1;
    chk("px_ready", px_ready_o, rdy);
    if (vld && rdy) void'(src_q.pop_front());
    cyc++;
    @(negedge clk_i);
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; px_valid_i = 1'b0; px_sof_i = 1'b0;
    #1;
    chk("rst_data", px_data_o, 0);
    chk("rst_de", de_o, 0);
    chk("rst_hsync", hsync_o, 0);
    chk("rst_vsync", vsync_o, 0);
    chk("rst_uf", underflow_o, 0);
    chk("rst_ma", misalign_o, 0);
    chk("rst_ready", px_ready_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    src_q.delete();
    col.delete();
    vs_rise.delete();
    cyc = 0; uf_seen = 0; ma_seen = 0; vs_prev = 0; win_lo = 1 << 30;
  endtask

  task automatic push_frame(input int n, input logic [23:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = rnd ? 24'($urandom) : base + 24'(i);
      b.sof = (i == 0);
      src_q.push_back(b);
    end
  endtask

  typedef struct { bit en, vld, sof; logic [23:0] d; bit rdy, de; } vec_t;
  vec_t tbl[9];

  initial begin
    bit dropped;
    beat_t jb;
    tbl[0] = '{1'b0, 1'b1, 1'b1, 24'hABCDEF, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 24'h111111, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 24'h123456, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 24'h654321, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 24'h777777, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 24'h0F0F0F, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};

    rst_i = 1'b1; en_i = 1'b0; px_valid_i = 1'b0; px_sof_i = 1'b0; px_data_i = '0;
    @(negedge clk_i);
    do_reset();

    // Directed vectors around enable: hunting, holding SOF, forced back by en low.
    for (int i = 0; i < 9; i++) begin
      en_i = tbl[i].en; px_valid_i = tbl[i].vld; px_sof_i = tbl[i].sof; px_data_i = tbl[i].d;
      #1;
      chk("tbl_ready", px_ready_o, tbl[i].rdy);
      @(negedge clk_i);
      chk("tbl_de", de_o, tbl[i].de);
      chk("tbl_data", px_data_o, 0);
      chk("tbl_hsync", hsync_o, 0);
      chk("tbl_vsync", vsync_o, 0);
      chk("tbl_uf", underflow_o, 0);
      chk("tbl_ma", misalign_o, 0);
    end

    // Idle with en low for 50 cycles while upstream offers beats.
    model_reset();
    push_frame(32, 24'h0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, $urandom_range(0, 1) == 1);
    chk("idle_no_consume", src_q.size(), 32);

    // Discard junk, then continuous ramp frames: timing and pixel order.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      jb.data = 24'hF00000 + 24'(i); jb.sof = 0; src_q.push_back(jb);
    end
    for (int f = 0; f < 5; f++) push_frame(32, 24'(f << 16), 1'b0);
    win_lo = FT + 1;
    for (int i = 0; i < 5 * FT; i++) step(1'b1, 1'b1);
    chk("order_len", col.size(), 32);
    if (col.size() == 32) begin
      for (int i = 0; i < 32; i++) chk("order", col[i], i);
    end
    chk("vs_edges", vs_rise.size() >= 2, 1);
    if (vs_rise.size() >= 2) chk("frame_period", vs_rise[1] - vs_rise[0], FT);
    chk("A_underflows", uf_seen, 0);
    chk("A_misaligns", ma_seen, 0);

    // Underflow: drop pixel 3 of line 1 in the first locked frame.
    do_reset();
    for (int f = 0; f < 5; f++) push_frame(32, 24'(f << 16), 1'b0);
    win_lo = FT + 1;
    dropped = 0;
    for (int i = 0; i < 4 * FT; i++) begin
      if (mode == 2 && pos == HT + 3 && !dropped) begin
        dropped = 1;
        step(1'b1, 1'b0);
      end else step(1'b1, 1'b1);
    end
    chk("B_underflows", uf_seen, 1);
    chk("B_len", col.size(), 32);
    if (col.size() == 32) begin
      chk("B_black", col[11], 0);
      chk("B_shift", col[12], 24'h00000B);
      chk("B_last", col[31], 24'h00001E);
    end

    // Early SOF at pixel 5 of line 2 of the second frame.
    do_reset();
    push_frame(32, 24'h000000, 1'b0);
    push_frame(2 * HA + 5, 24'h010000, 1'b0);
    push_frame(32, 24'h020000, 1'b0);
    push_frame(32, 24'h030000, 1'b0);
    win_lo = 2 * FT + 1;
    for (int i = 0; i < 5 * FT; i++) step(1'b1, 1'b1);
    chk("C_misaligns", ma_seen, 1);
    chk("C_underflows", uf_seen, 0);
    chk("C_len", col.size(), 32);
    if (col.size() == 32) begin
      chk("C_before", col[20], 24'h010014);
      chk("C_black", col[21], 0);
      chk("C_tail", col[31], 0);
    end

    // Random stream with gaps, odd frame lengths, en drops and mid-frame reset.
    do_reset();
    for (int f = 0; f < 12; f++) push_frame((f % 4 == 3) ? $urandom_range(20, 40) : 32, 24'h0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
        for (int f = 0; f < 10; f++) push_frame((f % 3 == 2) ? $urandom_range(20, 40) : 32, 24'h0, 1'b1);
      end
      step(!(i >= 1200 && i < 1210), $urandom_range(0, 15) != 0);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
